ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Parametrised, pipelined successor to the combinational main decoder.
- Decodes the ID-stage opcode into a control bundle, then carries that bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Handles hazard-unit stall and flush, turns illegal opcodes into bubbles, and counts illegal opcodes.
- Sits between the instruction register and the datapath stage muxes.

Parameters:
- OP_W, 6, opcode width
- ALUOP_W, 2, aluop field width
- CNT_W, 8, illegal-opcode counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_d  in  OP_W  opcode of the instruction in ID
- valid_d  in  1  ID holds a real instruction
- stall_e  in  1  hold the EX control register; MEM loads a bubble
- flush_e  in  1  load a bubble into the EX control register
- branch_e, bne_e, jump_e, alusrc_e  out  1 each  EX-stage control
- regdst_e  out  2  EX-stage register-destination select
- aluop_e  out  ALUOP_W  EX-stage ALU op
- memwrite_m  out  1  MEM-stage store enable
- regwrite_w  out  1  WB-stage register-file write
- memtoreg_w  out  2  WB-stage writeback select
- valid_e, valid_m, valid_w  out  1 each  stage holds a real instruction
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes
- exc_e  out  1  illegal-opcode exception, only with CTRL_EXC_EN

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-low, rst_n.
- Reset values: all control registers, valid bits, illegal_cnt and exc_e are 0, so every output is 0.
- Decode in ID is combinational. Fields are listed as bne, regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop; aluop values are zero-extended to ALUOP_W.
  - 000000 R: 0,1,01,0,0,0,00,0,10
  - 100011 LW: 0,1,00,1,0,0,01,0,00
  - 101011 SW: 0,0,00,1,0,1,00,0,00
  - 000100 BEQ: 0,0,00,0,1,0,00,0,01
  - 001000 ADDI: 0,1,00,1,0,0,00,0,00
  - 000010 J: 0,0,00,0,0,0,00,1,00
  - 001010 SLTI: 0,1,00,1,0,0,00,0,11
  - 000101 BNE: 1,0,00,0,0,0,00,0,01
  - 000011 JAL: 0,1,10,0,0,0,10,1,00
  - Any other opcode is illegal and decodes to all-zero controls. An X output is never produced.
- Bubble: all controls 0 and valid 0.
- Stage timing: each register stage adds 1 cycle. ID at cycle N gives EX at N+1, MEM at N+2, WB at N+3.
- Per-edge update priority:
  - stall_e=1: EX holds its contents; MEM loads a bubble; WB loads from MEM. flush_e is ignored.
  - stall_e=0, flush_e=1: EX loads a bubble; MEM and WB advance normally.
  - Otherwise: EX loads the decoded bundle with valid_e = valid_d & legal. MEM and WB advance.
- MEM and WB carry only the fields their stage consumes, plus valid.
- illegal_cnt:
  - Increments when valid_d=1, the opcode is illegal, and the EX register actually loads from ID (stall_e=0 and flush_e=0).
  - Saturates at all-ones and does not wrap.
- Reset mid-operation clears every stage immediately, asynchronously. The first valid result appears in EX one edge after rst_n deasserts.
- valid_d=0 always produces a bubble and never counts, whatever op_d holds.

Optional Feature:
- Macro: CTRL_EXC_EN
- Defined:
  - An illegal valid opcode that loads into EX sets exc_e=1 for exactly that EX occupancy.
  - exc_e holds under stall_e. It clears when EX is flushed or loads a new instruction.
  - Controls stay a bubble.
- Undefined: exc_e is tied to 0 and illegal opcodes become silent bubbles. illegal_cnt behaves identically either way.

Test Plan:
- Reset then LW (100011) with valid_d=1 -> next edge alusrc_e=1, valid_e=1; +1 edge memwrite_m=0, valid_m=1; +2 edges regwrite_w=1, memtoreg_w=01.
- JAL (000011) then BNE (000101) back-to-back -> EX shows regdst_e=10, jump_e=1, then bne_e=1, aluop_e=01; WB later shows memtoreg_w=10, regwrite_w=1, then regwrite_w=0.
- SW in EX and stall_e=1 for 2 cycles -> memwrite_m=0 and valid_m=0 for 2 cycles, EX holds SW; memwrite_m=1 one cycle after stall_e falls.
- flush_e=1 with R-type in ID -> valid_e=0, aluop_e=00, regwrite_w=0 three edges later; illegal_cnt unchanged.
- 300 consecutive illegal opcodes (111111, valid_d=1) -> illegal_cnt saturates at 255; with CTRL_EXC_EN exc_e=1 throughout, regwrite_w stays 0.
- rst_n low mid-stream with ADDI in MEM -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main-decoder control path.
//
// Decodes the ID-stage opcode into a control bundle. The bundle is then
// carried through the ID/EX, EX/MEM and MEM/WB control registers. Each stage
// register keeps only the fields that its own stage or later stages consume.
// The block handles hazard-unit stall/flush, turns illegal opcodes into
// bubbles, and keeps a saturating count of illegal opcodes.
//
// Optional feature: define CTRL_EXC_EN to drive exc_e. When it is undefined,
// exc_e is tied to 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op_d, valid_d         opcode in ID, and ID holds a real instruction
//   stall_e               EX holds its contents, MEM loads a bubble
//   flush_e               EX loads a bubble (ignored while stall_e is high)
//   branch_e .. aluop_e   EX-stage controls
//   memwrite_m            MEM-stage store enable
//   regwrite_w            WB-stage register-file write enable
//   memtoreg_w            WB-stage writeback select
//   valid_e/_m/_w         the stage holds a real instruction
//   illegal_cnt           saturating count of illegal opcodes loaded into EX
//   exc_e                 illegal-opcode exception for the current EX occupancy
module ctrl_pipe #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op_d,
    input  logic               valid_d,
    input  logic               stall_e,
    input  logic               flush_e,
    output logic               branch_e,
    output logic               bne_e,
    output logic               jump_e,
    output logic               alusrc_e,
    output logic [1:0]         regdst_e,
    output logic [ALUOP_W-1:0] aluop_e,
    output logic               memwrite_m,
    output logic               regwrite_w,
    output logic [1:0]         memtoreg_w,
    output logic               valid_e,
    output logic               valid_m,
    output logic               valid_w,
    output logic [CNT_W-1:0]   illegal_cnt,
    output logic               exc_e
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);

    // Combinational decode of the ID opcode.
    logic               dec_bne, dec_regwrite, dec_alusrc, dec_branch;
    logic               dec_memwrite, dec_jump, dec_legal;
    logic [1:0]         dec_regdst, dec_memtoreg;
    logic [ALUOP_W-1:0] dec_aluop;

    always_comb begin
        dec_bne      = 1'b0;
        dec_regwrite = 1'b0;
        dec_regdst   = 2'b00;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 2'b00;
        dec_jump     = 1'b0;
        dec_aluop    = '0;
        dec_legal    = 1'b1;
        case (op_d)
            OP_R:    begin dec_regwrite = 1'b1; dec_regdst = 2'b01; dec_aluop = ALUOP_W'(2'b10); end
            OP_LW:   begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_memtoreg = 2'b01; end
            OP_SW:   begin dec_alusrc = 1'b1; dec_memwrite = 1'b1; end
            OP_BEQ:  begin dec_branch = 1'b1; dec_aluop = ALUOP_W'(2'b01); end
            OP_ADDI: begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; end
            OP_J:    begin dec_jump = 1'b1; end
            OP_SLTI: begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluop = ALUOP_W'(2'b11); end
            OP_BNE:  begin dec_bne = 1'b1; dec_aluop = ALUOP_W'(2'b01); end
            OP_JAL:  begin dec_regwrite = 1'b1; dec_regdst = 2'b10; dec_memtoreg = 2'b10; dec_jump = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    // EX loads from ID only when the stage is neither stalled nor flushed.
    // A slot that is not a legal, valid instruction is loaded as a bubble.
    logic load_e, take_d, illegal_d;
    assign load_e    = ~stall_e & ~flush_e;
    assign take_d    = valid_d & dec_legal;
    assign illegal_d = valid_d & ~dec_legal;

    // Fields that EX does not use itself but still carries toward MEM and WB.
    logic       memwrite_e, regwrite_e;
    logic [1:0] memtoreg_e;
    // Fields that MEM carries toward WB.
    logic       regwrite_m;
    logic [1:0] memtoreg_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_e    <= 1'b0;
            bne_e       <= 1'b0;
            jump_e      <= 1'b0;
            alusrc_e    <= 1'b0;
            regdst_e    <= 2'b00;
            aluop_e     <= '0;
            memwrite_e  <= 1'b0;
            regwrite_e  <= 1'b0;
            memtoreg_e  <= 2'b00;
            valid_e     <= 1'b0;
            memwrite_m  <= 1'b0;
            regwrite_m  <= 1'b0;
            memtoreg_m  <= 2'b00;
            valid_m     <= 1'b0;
            regwrite_w  <= 1'b0;
            memtoreg_w  <= 2'b00;
            valid_w     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            // ID/EX register. A stall holds the contents, so it needs no branch.
            if (!stall_e) begin
                branch_e   <= load_e & take_d & dec_branch;
                bne_e      <= load_e & take_d & dec_bne;
                jump_e     <= load_e & take_d & dec_jump;
                alusrc_e   <= load_e & take_d & dec_alusrc;
                regdst_e   <= (load_e && take_d) ? dec_regdst : 2'b00;
                aluop_e    <= (load_e && take_d) ? dec_aluop : '0;
                memwrite_e <= load_e & take_d & dec_memwrite;
                regwrite_e <= load_e & take_d & dec_regwrite;
                memtoreg_e <= (load_e && take_d) ? dec_memtoreg : 2'b00;
                valid_e    <= load_e & take_d;
            end
            // EX/MEM register. A bubble enters MEM while EX is held.
            memwrite_m <= ~stall_e & memwrite_e;
            regwrite_m <= ~stall_e & regwrite_e;
            memtoreg_m <= stall_e ? 2'b00 : memtoreg_e;
            valid_m    <= ~stall_e & valid_e;
            // MEM/WB register always advances.
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
            valid_w    <= valid_m;
            // The counter saturates at all-ones and does not wrap.
            if (load_e && illegal_d && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

`ifdef CTRL_EXC_EN
    // The exception flag follows the EX occupancy. It holds under stall,
    // clears on flush, and is refreshed whenever EX loads from ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exc_e <= 1'b0;
        else if (!stall_e)
            exc_e <= load_e & illegal_d;
    end
`else
    assign exc_e = 1'b0;
`endif

endmodule
